// File: rtl/fsm_capture_pkg.sv
// Shared encodings for the capture block and its sequencer.
// State codes and widths live here so both sides agree.
package fsm_capture_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1
  } state_t;

endpackage

// File: rtl/fsm_capture_outreg.sv
// Valid/ready result register.
// Drops a new result while one is pending and flags overflow.
module fsm_capture_outreg
  import fsm_capture_pkg::*;
#(
  parameter int DW = 12,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pub,
  input  logic [DW-1:0] pub_data,
  input  logic [CW-1:0] pub_count,
  input  logic          clr_ovf,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_valid,
  output logic          overflow
);

  logic take;
  logic drop;

  assign take = pub && (!out_valid || out_ready);
  assign drop = pub && out_valid && !out_ready;

  // Result slot: load on publish, empty on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      out_data  <= pub_data;
      out_count <= pub_count;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_capture.sv
// Sample accumulator driven by the control sequencer.
// CAPTURE_SAT_EN: accumulator saturates instead of wrapping.
module fsm_capture
  import fsm_capture_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctl,
  input  logic            done,
  input  logic [W-1:0]    din,
  input  logic            clr_ovf,
  output logic [W+CW-1:0] out_data,
  output logic [CW-1:0]   out_count,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic            busy
);

  localparam int AW = W + CW;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW:0]   sum_ext;
  logic [AW-1:0] acc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          pub;

  assign sum_ext = {1'b0, acc} + {{(CW+1){1'b0}}, din};

`ifdef CAPTURE_SAT_EN
  assign acc_nxt = sum_ext[AW] ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
  assign acc_nxt = sum_ext[AW-1:0];
`endif

  assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
  assign pub     = (state == ACC) && done;
  assign busy    = (state == ACC);

  // Sequencer-following FSM with accumulator and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!done && ctl) begin
            acc   <= {{CW{1'b0}}, din};
            cnt   <= {{(CW-1){1'b0}}, 1'b1};
            state <= ACC;
          end
        end
        ACC: begin
          if (done) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (ctl) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
          end
        end
        default: begin
          acc   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  fsm_capture_outreg #(
    .DW(AW),
    .CW(CW)
  ) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .pub      (pub),
    .pub_data (acc),
    .pub_count(cnt),
    .clr_ovf  (clr_ovf),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .overflow (overflow)
  );

endmodule

// File: doc/fsm_capture.md
Name: fsm_capture

Overview:
- Downstream consumer of the 3-state control sequencer (IDLE -> GO -> DONE).
- While ctl is high, accumulates input samples. On each done pulse, publishes the sum and sample count to a downstream consumer over a valid/ready handshake.
- Detects dropped results: a result that arrives while the previous one is still pending sets a sticky overflow flag.

Parameters:
- W, 8, input sample width in bits.
- CW, 4, sample-counter width; the accumulator is W+CW bits wide.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ctl  input  1  sample-enable from the sequencer.
- done  input  1  end-of-sequence pulse from the sequencer.
- din  input  W  unsigned sample.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- out_data  output  W+CW  published sum.
- out_count  output  CW  number of samples in the published sum.
- out_valid  output  1  result pending.
- out_ready  input  1  downstream accepts the result.
- overflow  output  1  sticky flag: a result was dropped.
- busy  output  1  block is in state ACC.

Behaviour:
- Reset values: acc=0, cnt=0, state=IDLE, out_data=0, out_count=0, out_valid=0, overflow=0, busy=0.
- State register is 2 bits. IDLE=0, ACC=1. Codes 2 and 3 are illegal and go to IDLE with acc and cnt cleared.
- Priority rule: when done=1, ctl is ignored. The sequencer holds ctl high through its DONE cycle.
- IDLE, ctl=1, done=0: acc<=din, cnt<=1, go to ACC.
- IDLE, done=1: no publish, no state change.
- IDLE, otherwise: hold.
- ACC, done=1: publish (see below), acc<=0, cnt<=0, go to IDLE.
- ACC, ctl=1, done=0: acc<=acc+din, cnt<=cnt+1.
- ACC, ctl=0, done=0: hold acc and cnt; stay in ACC. This covers gaps between samples.
- Counter saturation: cnt stops at 2^CW-1. Further samples are still added to acc.
- Arithmetic: unsigned. Without CAPTURE_SAT_EN, acc wraps modulo 2^(W+CW).
- Publish when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle:
  - out_data<=acc and out_count<=cnt on the next edge; out_valid=1.
  - Latency: done edge to out_valid=1 is 1 cycle.
- Publish when out_valid=1 and out_ready=0: the new result is dropped, the old result is held unchanged, overflow<=1.
- Handshake:
  - Transfer occurs on a cycle with out_valid=1 and out_ready=1. Next cycle out_valid=0, unless a publish happens in the same cycle.
  - out_data and out_count are stable while out_valid=1 and out_ready=0.
- overflow: set as above. Cleared by clr_ovf=1 on the next edge. A set event in the same cycle as clr_ovf wins (overflow stays 1).
- busy = (state==ACC), registered-state decode.
- Asynchronous reset mid-accumulation or mid-handshake discards everything and returns all outputs to their reset values immediately.

Optional Feature:
- Macro: CAPTURE_SAT_EN.
- Defined: acc saturates at 2^(W+CW)-1 instead of wrapping.
- Not defined: acc wraps. Logic is identical otherwise.

Decomposition:
- Shared package holds the state localparams (IDLE, ACC) and the state-width constant, shared with the sequencer's encoding definitions.
- One natural sub-module: fsm_capture_outreg, the valid/ready output register with drop/overflow logic. The top level contains the FSM and accumulator.

Test Plan:
- Reset: assert rst_n=0 mid-ACC with acc=0x25 -> all outputs 0 immediately; state=IDLE after release.
- Single sequence: ctl=1 with din=0x12 for 1 cycle, then done=1 (ctl still 1, din=0x55) -> next cycle out_valid=1, out_data=0x012, out_count=1 (the din=0x55 sample is ignored).
- Gapped accumulation: samples 3, 4, 5 with one ctl=0 cycle between each, then done -> out_data=12, out_count=3.
- Back-pressure: out_ready=0, two full sequences (first sum 7, second sum 9) -> out_data stays 7 and overflow=1; then out_ready=1 -> transfer; then clr_ovf=1 -> overflow=0.
- Accept+publish same cycle: out_valid=1 with old=7, out_ready=1 on the done cycle of a sum-9 sequence -> out_valid stays 1, out_data=9, overflow=0.
- Saturation, W=8 CW=4: 20 samples of 0xFF -> out_count=15. Without CAPTURE_SAT_EN, out_data=0x3EC (20*255 mod 4096). With CAPTURE_SAT_EN, out_data=0xFFF.
